limb_add_seq: RTL and testbench
===============================

// Module: limb_add_seq
// PURPOSE
//   Multi-precision add sequencer sitting directly upstream of the adder stage.
//   Splits two NLIMBS*WIDTH-bit operands into WIDTH-bit limbs.
//   Drives one limb pair per cycle onto the adder's x/y/cin inputs and reads
//   back the adder's combinational sum sm in the same cycle.
//   Chains the carry limb to limb and assembles the full-width result, carry-out
//   and zero flag.
// PARAMETERS
//   WIDTH   8   limb width; width of adder x/y
//   SWIDTH  9   adder sum width; must equal WIDTH+1 (sm[WIDTH] is limb carry)
//   NLIMBS  4   number of limbs per operand (>=2); total width TW=WIDTH*NLIMBS
// PORTS
//   clk      in   1       clock, rising edge
//   rst_n    in   1       reset, asynchronous, active-low
//   start    in   1       request: capture op_a/op_b/cin_in (honoured in IDLE only)
//   op_a     in   TW      operand A
//   op_b     in   TW      operand B
//   cin_in   in   1       carry-in to limb 0
//   busy     out  1       1 while in RUN or DONE
//   x        out  WIDTH   limb of A to adder
//   y        out  WIDTH   limb of B to adder
//   cin      out  1       carry to adder
//   sm       in   SWIDTH  adder combinational sum for current x/y/cin
//   result   out  TW      assembled sum, valid from done onward
//   cout     out  1       carry out of top limb
//   zero     out  1       1 when result==0 (cout excluded)
//   done     out  1       1-cycle pulse, result/cout/zero valid
// BEHAVIOUR
//   Reset: FSM=IDLE; busy, done, cout, zero, x, y, cin = 0; result=0; idx=0; carry=0.
//   Reset asserted mid-operation: operation aborted, same values, no done pulse.
//   FSM IDLE:
//     - start=1: latch op_a, op_b; carry<=cin_in; idx<=0; go RUN.
//     - outputs result/cout/zero hold last values.
//   FSM RUN (exactly NLIMBS cycles):
//     - x = A[idx*WIDTH +: WIDTH], y = B[idx*WIDTH +: WIDTH], cin = carry, all registered/stable.
//     - Each edge: result[idx*WIDTH +: WIDTH] <= sm[WIDTH-1:0]; carry <= sm[WIDTH]; idx++.
//     - Edge at idx==NLIMBS-1: cout <= sm[WIDTH]; zero <= (all limbs incl. this one ==0); go DONE.
//   FSM DONE (1 cycle): done=1, busy=1; next state IDLE unconditionally.
//   Outside RUN: x = y = 0, cin = 0.
//   Latency: start sampled at edge 0 -> done high in cycle NLIMBS+1; next start accepted in the cycle after done.
//   start in RUN or DONE: ignored, no queuing; op_a/op_b changes while busy have no effect.
//   Zero tracking: running AND of per-limb (sm[WIDTH-1:0]==0), cleared to 1 at start capture.
//   result limbs not yet written during RUN keep previous contents; only valid at/after done.
//   sm is consumed same cycle (adder combo path); no adder register path used.
//   Arithmetic: result = (A + B + cin_in) mod 2^TW; cout = bit TW of the full sum.
// TESTING (WIDTH=8, NLIMBS=4)
//   A=0x000000FF, B=0x00000001, cin_in=0 -> result=0x00000100, cout=0, zero=0, done 5 cycles after start.
//   A=0xFFFFFFFF, B=0x00000000, cin_in=1 -> result=0x00000000, cout=1, zero=1.
//   A=B=0x7FFFFFFF, cin_in=1 -> result=0xFFFFFFFF, cout=0, zero=0; per-cycle x/y=FF,FF,FF,7F.
//   start pulsed in RUN with different operands -> ignored; result from first operands only, one done pulse.
//   rst_n low in 2nd RUN cycle -> all outputs 0, no done; next start with A=1, B=2 -> result=3.
//   start in cycle after done, 100-op random A/B/cin_in -> result/cout match 33-bit model every done.

Source files
------------

// File: rtl/limb_add_seq.sv
// Multi-precision add sequencer: walks NLIMBS limb pairs through an external
// combinational adder one per cycle, chaining the carry and assembling the sum.
module limb_add_seq #(
    parameter int WIDTH  = 8,
    parameter int SWIDTH = 9,
    parameter int NLIMBS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [WIDTH*NLIMBS-1:0]   op_a,
    input  logic [WIDTH*NLIMBS-1:0]   op_b,
    input  logic                      cin_in,
    output logic                      busy,
    output logic [WIDTH-1:0]          x,
    output logic [WIDTH-1:0]          y,
    output logic                      cin,
    input  logic [SWIDTH-1:0]         sm,
    output logic [WIDTH*NLIMBS-1:0]   result,
    output logic                      cout,
    output logic                      zero,
    output logic                      done
);

    // state | meaning
    // IDLE  | waiting for start, result/cout/zero hold last values
    // RUN   | one limb pair on x/y/cin per cycle, NLIMBS cycles
    // DONE  | one-cycle done pulse, then back to IDLE
    localparam int TW   = WIDTH * NLIMBS;
    localparam int IDXW = (NLIMBS > 1) ? $clog2(NLIMBS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [TW-1:0]    a_q,      a_d;
    logic [TW-1:0]    b_q,      b_d;
    logic [WIDTH-1:0] x_q,      x_d;
    logic [WIDTH-1:0] y_q,      y_d;
    logic             cin_q,    cin_d;
    logic [IDXW-1:0]  idx_q,    idx_d;
    logic [TW-1:0]    result_q, result_d;
    logic             cout_q,   cout_d;
    logic             zero_q,   zero_d;
    logic             zacc_q,   zacc_d;
    logic             last_limb;
    logic             limb_zero;

    assign last_limb = (idx_q == IDXW'(NLIMBS - 1));
    assign limb_zero = (sm[WIDTH-1:0] == '0);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        x_d      = x_q;
        y_d      = y_q;
        cin_d    = cin_q;
        idx_d    = idx_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        zacc_d   = zacc_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Limb 0 goes straight onto x/y; the rest queue in a_q/b_q
                    x_d     = op_a[WIDTH-1:0];
                    y_d     = op_b[WIDTH-1:0];
                    a_d     = op_a >> WIDTH;
                    b_d     = op_b >> WIDTH;
                    cin_d   = cin_in;
                    idx_d   = '0;
                    zacc_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int l = 0; l < NLIMBS; l++) begin
                    if (idx_q == IDXW'(l)) begin
                        result_d[l*WIDTH +: WIDTH] = sm[WIDTH-1:0];
                    end
                end
                zacc_d = zacc_q & limb_zero;
                if (last_limb) begin
                    cout_d  = sm[WIDTH];
                    zero_d  = zacc_q & limb_zero;
                    x_d     = '0;
                    y_d     = '0;
                    cin_d   = 1'b0;
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    x_d   = a_q[WIDTH-1:0];
                    y_d   = b_q[WIDTH-1:0];
                    a_d   = a_q >> WIDTH;
                    b_d   = b_q >> WIDTH;
                    cin_d = sm[WIDTH];
                    idx_d = idx_q + IDXW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            cin_q    <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            zacc_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cin_q    <= cin_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            zacc_q   <= zacc_d;
        end
    end

    assign busy   = (state_q == S_RUN) || (state_q == S_DONE);
    assign done   = (state_q == S_DONE);
    assign x      = x_q;
    assign y      = y_q;
    assign cin    = cin_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_limb_add_seq.sv
// Scoreboard bench for limb_add_seq with a behavioural combinational adder on sm.
module tb_limb_add_seq;

    localparam int W  = 8;
    localparam int NL = 4;
    localparam int TW = W * NL;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [TW-1:0] op_a = '0;
    logic [TW-1:0] op_b = '0;
    logic          cin_in = 1'b0;
    logic          busy;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic          cin;
    logic [W:0]    sm;
    logic [TW-1:0] result;
    logic          cout;
    logic          zero;
    logic          done;

    limb_add_seq #(.WIDTH(W), .SWIDTH(W+1), .NLIMBS(NL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
        .cin_in(cin_in), .busy(busy), .x(x), .y(y), .cin(cin), .sm(sm),
        .result(result), .cout(cout), .zero(zero), .done(done)
    );

    assign sm = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TW-1:0] res;
        logic          co;
        logic          z;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   passed = 0;
    int   done_cnt = 0;
    int   ops_expected = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: pops the oldest expected response on every done pulse
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (q.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", 64'(result), 64'(e.res));
                chk("cout",   64'(cout),   64'(e.co));
                chk("zero",   64'(zero),   64'(e.z));
            end
        end
    end

    function automatic logic exp_cin(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                     input logic c, input int k);
        logic [TW:0] part;
        logic [TW:0] mask;
        mask = ({{TW{1'b0}}, 1'b1} << (k * W)) - 1;
        part = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {{TW{1'b0}}, c};
        return part[k * W];
    endfunction

    // Called just after a rising edge; returns just after the edge ending DONE.
    task automatic run_op(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic c,
                          input bit check_lat, input bit glitch);
        logic [TW:0] full;
        exp_t e;
        int n;
        bit seen;
        full = {1'b0, a} + {1'b0, b} + {{TW{1'b0}}, c};
        e.res = full[TW-1:0];
        e.co  = full[TW];
        e.z   = (full[TW-1:0] == '0);
        q.push_back(e);
        ops_expected++;
        op_a = a; op_b = b; cin_in = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                chk("busy_done", 64'(busy), 64'd1);
                chk("x_idle", 64'(x), 64'd0);
                break;
            end
            if (n <= NL) begin
                chk("x_limb", 64'(x), 64'(a[(n-1)*W +: W]));
                chk("y_limb", 64'(y), 64'(b[(n-1)*W +: W]));
                chk("cin_limb", 64'(cin), 64'(exp_cin(a, b, c, n-1)));
                chk("busy_run", 64'(busy), 64'd1);
            end
            if (glitch) begin
                start = 1'b1;
                op_a = TW'($urandom); op_b = TW'($urandom); cin_in = ~c;
            end
        end
        if (!seen) begin
            total++;
            $display("FAIL done_timeout: got no done expected done within 20 cycles");
        end else if (check_lat) begin
            chk("latency", 64'(n), 64'(NL + 1));
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        int d0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_xycin", 64'({x, y, cin}), 64'd0);
        chk("rst_cz", 64'({cout, zero}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b1, 1'b0);
        run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1, 1'b0);
        run_op(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("idle_hold_result", 64'(result), 64'hFFFFFFFF);
        chk("idle_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;

        d0 = done_cnt;
        run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("glitch_one_done", 64'(done_cnt - d0), 64'd1);

        // Abort during the second RUN cycle
        op_a = 32'hDEADBEEF; op_b = 32'h01020304; cin_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        d0 = done_cnt;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_result", 64'(result), 64'd0);
        chk("abort_xycin", 64'({x, y, cin}), 64'd0);
        chk("abort_cz_done", 64'({cout, zero, done}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        @(posedge clk); #1;
        run_op(32'h00000001, 32'h00000002, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 100; i++) begin
            run_op(TW'($urandom), TW'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("queue_empty", 64'(q.size()), 64'd0);
        chk("done_count", 64'(done_cnt), 64'(ops_expected));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish before 2ms");
        $display("%0d/%0d checks passed", passed, total + 1);
        $fatal(1, "timeout");
    end

endmodule
